// File: rtl/two_way_cache_ctrl.sv
// two_way_cache_ctrl: write-through, no-write-allocate two-way set-associative data cache controller
module two_way_cache_ctrl #(
    parameter int ADDR_SIZE       = 32,
    parameter int NUM_SETS        = 16,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req_valid,
    output logic                 cpu_req_ready,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_resp_valid,
    output logic [31:0]          cpu_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic [ADDR_SIZE-1:0] lru_addr,
    output logic                 lru_replace,
    input  logic                 lru_preferred
);
    localparam int WB = $clog2(WORDS_PER_BLOCK);
    localparam int OB = 2 + WB;
    localparam int SB = $clog2(NUM_SETS);
    localparam int TB = ADDR_SIZE - SB - OB;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

    state_t                 r_state, w_next;
    logic                   r_we;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_resp;
    logic [WB-1:0]          r_cnt;
    logic                   r_victim;
    logic [1:0]             r_valid [NUM_SETS];
    logic [TB-1:0]          r_tag   [NUM_SETS][2];
    logic [31:0]            r_data  [NUM_SETS][2][WORDS_PER_BLOCK];

    logic [TB-1:0]          w_tag;
    logic [SB-1:0]          w_set;
    logic [WB-1:0]          w_word;
    logic                   w_hit0, w_hit1, w_hit, w_way, w_last, w_fill;

    assign w_tag  = r_addr[ADDR_SIZE-1 -: TB];
    assign w_set  = r_addr[OB +: SB];
    assign w_word = r_addr[2 +: WB];
    assign w_hit0 = r_valid[w_set][0] && r_tag[w_set][0] == w_tag;
    assign w_hit1 = r_valid[w_set][1] && r_tag[w_set][1] == w_tag;
    assign w_hit  = w_hit0 | w_hit1;
    assign w_way  = w_hit1;
    assign w_last = r_cnt == WB'(WORDS_PER_BLOCK - 1);
    assign w_fill = r_state == REFILL && mem_ack;

    assign cpu_req_ready  = r_state == IDLE && !rst;
    assign cpu_resp_valid = r_state == RESP;
    assign cpu_rdata      = (r_state == RESP && !r_we) ? r_resp : '0;
    assign mem_req        = r_state == REFILL || r_state == WRITE;
    assign mem_we         = r_state == WRITE;
    assign mem_addr       = r_state == REFILL ? {w_tag, w_set, r_cnt, 2'b00} :
                            r_state == WRITE  ? {r_addr[ADDR_SIZE-1:2], 2'b00} : '0;
    assign mem_wdata      = r_state == WRITE ? r_wdata : '0;
    assign lru_addr       = r_addr;
    // Hitting the preferred victim makes it most-recent, so the replacement unit must flip
    assign lru_replace    = (r_state == LOOKUP && w_hit && w_way == lru_preferred) || (w_fill && w_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = cpu_req_valid ? LOOKUP : IDLE;
            LOOKUP:  w_next = r_we ? WRITE : w_hit ? RESP : REFILL;
            REFILL:  w_next = (mem_ack && w_last) ? RESP : REFILL;
            WRITE:   w_next = mem_ack ? RESP : WRITE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_resp   <= '0;
            r_cnt    <= '0;
            r_victim <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cpu_req_valid) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if (r_state == LOOKUP && !r_we) begin
                if (w_hit) r_resp <= r_data[w_set][w_way][w_word];
                r_cnt    <= '0;
                r_victim <= lru_preferred;
            end
            if (w_fill) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == w_word) r_resp <= mem_rdata;
                if (w_last) r_valid[w_set][r_victim] <= 1'b1;
            end
        end
    end

    // Arrays carry no reset; a line is only usable once its valid bit is set
    always_ff @(posedge clk) begin
        if (!rst && r_state == LOOKUP && r_we && w_hit) r_data[w_set][w_way][w_word] <= r_wdata;
        if (!rst && w_fill) begin
            r_data[w_set][r_victim][r_cnt] <= mem_rdata;
            if (w_last) r_tag[w_set][r_victim] <= w_tag;
        end
    end
endmodule

// File: tb/tb_two_way_cache_ctrl.sv
// tb_two_way_cache_ctrl: table-driven bench with memory, LRU-unit and response-scoreboard models
module tb_two_way_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_req_ready, cpu_resp_valid;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] lru_addr;
    logic        lru_replace, lru_preferred;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          rd;
        int          wr;
        int          lru;
        int          lat;
    } vec_t;

    vec_t        vecs [19];
    logic [31:0] exp_q [$];
    logic [31:0] rd_log [$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [15:0] pref = '0;
    int          checks = 0, errors = 0;
    int          n_rd = 0, n_wr = 0, n_lru = 0;
    int          waits = 0, wcnt = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_addr = '0;

    two_way_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .lru_addr(lru_addr), .lru_replace(lru_replace), .lru_preferred(lru_preferred)
    );

    always #5 clk = ~clk;

    assign lru_preferred = pref[lru_addr[7:4]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : (32'hA000_0000 | a);
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] r, input int w, input int rd, input int wr,
                                input int lru, input int lat);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.rdata = r;
        v.waits = w; v.rd = rd; v.wr = wr; v.lru = lru; v.lat = lat;
        return v;
    endfunction

    // Memory: ack after `waits` stall cycles, data presented on the falling edge
    always @(negedge clk) begin
        if (mem_req && hold) chk("mem_addr_stable", mem_addr, hold_addr);
        if (mem_req && wcnt >= waits) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem_rd(mem_addr);
            wcnt = 0;
            hold = 1'b0;
        end else begin
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            hold      = mem_req;
            hold_addr = mem_addr;
            wcnt      = mem_req ? wcnt + 1 : 0;
        end
        if (cpu_resp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
        end
    end

    // LRU unit model and memory-side effects of completed transactions
    always @(posedge clk) begin
        if (rst) pref <= '0;
        else if (lru_replace) begin
            n_lru++;
            pref[lru_addr[7:4]] <= ~pref[lru_addr[7:4]];
        end
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                n_wr++;
                mem_arr[mem_addr] = mem_wdata;
            end else begin
                n_rd++;
                rd_log.push_back(mem_addr);
            end
        end
    end

    task automatic run_vec(input int i);
        vec_t v;
        int   b_rd, b_wr, b_lru, n;
        v = vecs[i];
        waits = v.waits;
        b_rd = n_rd; b_wr = n_wr; b_lru = n_lru;
        rd_log.delete();
        chk($sformatf("v%0d_ready", i), {31'd0, cpu_req_ready}, 32'd1);
        cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req_valid = 1'b1;
        exp_q.push_back(v.rdata);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        n = 1;
        while (!cpu_resp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d_latency", i), n, v.lat);
        @(posedge clk); #1;
        chk($sformatf("v%0d_mem_reads", i), n_rd - b_rd, v.rd);
        chk($sformatf("v%0d_mem_writes", i), n_wr - b_wr, v.wr);
        chk($sformatf("v%0d_lru_pulses", i), n_lru - b_lru, v.lru);
        if (v.rd == 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_refill_addr%0d", i, k), k < rd_log.size() ? rd_log[k] : 32'hFFFF_FFFF,
                    {v.addr[31:4], 4'h0} + 32'(4 * k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, n;
        for (int k = 0; k < 4; k++) mem_arr[32'h40 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
        //          we  addr        wdata         rdata         w  rd wr lru lat
        vecs[0]  = mk(0, 32'h040, 32'h0,        32'h11,        0, 4, 0, 1, 6);
        vecs[1]  = mk(0, 32'h048, 32'h0,        32'h33,        0, 0, 0, 0, 2);
        vecs[2]  = mk(0, 32'h440, 32'h0,        32'hA000_0440, 0, 4, 0, 1, 6);
        vecs[3]  = mk(0, 32'h044, 32'h0,        32'h22,        0, 0, 0, 1, 2);
        vecs[4]  = mk(0, 32'h840, 32'h0,        32'hA000_0840, 0, 4, 0, 1, 6);
        vecs[5]  = mk(0, 32'h44C, 32'h0,        32'hA000_044C, 0, 4, 0, 1, 6);
        vecs[6]  = mk(0, 32'h848, 32'h0,        32'hA000_0848, 0, 0, 0, 1, 2);
        vecs[7]  = mk(0, 32'h440, 32'h0,        32'hA000_0440, 0, 0, 0, 1, 2);
        vecs[8]  = mk(0, 32'h040, 32'h0,        32'h11,        0, 4, 0, 1, 6);
        vecs[9]  = mk(1, 32'h044, 32'hDEADBEEF, 32'h0,         0, 0, 1, 0, 3);
        vecs[10] = mk(0, 32'h044, 32'h0,        32'hDEADBEEF,  0, 0, 0, 0, 2);
        vecs[11] = mk(1, 32'h848, 32'h12345678, 32'h0,         0, 0, 1, 0, 3);
        vecs[12] = mk(0, 32'h848, 32'h0,        32'h12345678,  0, 4, 0, 1, 6);
        vecs[13] = mk(0, 32'h080, 32'h0,        32'hA000_0080, 0, 4, 0, 1, 6);
        vecs[14] = mk(0, 32'h040, 32'h0,        32'h11,        0, 4, 0, 1, 6);
        vecs[15] = mk(0, 32'h0C4, 32'h0,        32'hA000_00C4, 3, 4, 0, 1, 18);
        vecs[16] = mk(1, 32'h0C8, 32'hCAFEF00D, 32'h0,         3, 0, 1, 0, 6);
        vecs[17] = mk(0, 32'h0C8, 32'h0,        32'hCAFEF00D,  3, 0, 0, 0, 2);
        vecs[18] = mk(0, 32'h048, 32'h0,        32'h33,        0, 0, 0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, cpu_req_ready}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("reset_lru_replace", {31'd0, lru_replace}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, cpu_req_ready}, 32'd1);

        for (int i = 0; i <= 12; i++) run_vec(i);

        // Abort a refill with reset after its second word
        waits = 0;
        cpu_we = 1'b0; cpu_addr = 32'h80; cpu_req_valid = 1'b1;
        b = n_rd;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        n = 0;
        while (n_rd - b < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_two_acks", n_rd - b, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("abort_ready_in_reset", {31'd0, cpu_req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", {31'd0, cpu_req_ready}, 32'd1);

        for (int i = 13; i <= 18; i++) run_vec(i);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
